// File: rtl/dice_roll_sequencer.sv
// dice_roll_sequencer
//   Drives the 3-bit face select of the eight-sided dice decoder. While roll
//   is held the face spins one step every SPIN_DIV cycles. On release the
//   face decelerates: SLOW_STEPS further steps, each interval twice the
//   previous one. The face then settles and holds until the next press.
//
//   Optional feature (macro DICE_BLINK_EN): after settling, blank toggles
//   every BLINK_DIV cycles, six toggles in all (three blinks), ending at 0.
//   A press during blinking clears blank and starts a new spin.
//   Without the macro, blank is tied to 0.
//
// Ports
//   clk      in   system clock, rising edge
//   rst      in   asynchronous reset, active-high
//   roll     in   debounced roll request, level, synchronous to clk
//   face     out  [2:0] current face, to dice decoder s[2:0]
//   rolling  out  high while spinning or decelerating
//   done     out  one-cycle pulse on the edge the face settles
//   blank    out  display blank request
//
// State table
//   IDLE    | after reset, face held, waiting for roll
//   SPIN    | roll held, fixed-rate face steps
//   SLOW    | roll released, interval doubles per step, roll ignored
//   SETTLED | final face held (blink sub-phase when enabled)

module dice_roll_sequencer #(
    parameter int SPIN_DIV   = 4,
    parameter int SLOW_STEPS = 4,
    parameter int TMR_W      = 16,
    parameter int BLINK_DIV  = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       roll,
    output logic [2:0] face,
    output logic       rolling,
    output logic       done,
    output logic       blank
);

    if (SPIN_DIV < 1) begin : g_bad_spin_div
        $error("SPIN_DIV must be >= 1");
    end
    if (SLOW_STEPS < 1) begin : g_bad_slow_steps
        $error("SLOW_STEPS must be >= 1");
    end
    if (BLINK_DIV < 1) begin : g_bad_blink_div
        $error("BLINK_DIV must be >= 1");
    end

    // k counts completed slow steps, so it must reach SLOW_STEPS.
    localparam int K_W = $clog2(SLOW_STEPS + 1);
    localparam logic [K_W-1:0]   K_LAST   = K_W'(SLOW_STEPS - 1);
    localparam logic [K_W-1:0]   K_ONE    = K_W'(1);
    localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);
    localparam logic [TMR_W-1:0] IVL_INIT = TMR_W'(SPIN_DIV);

    typedef enum logic [1:0] {IDLE, SPIN, SLOW, SETTLED} state_t;

    state_t           state, state_nxt;
    logic [TMR_W-1:0] tmr, tmr_nxt;
    logic [TMR_W-1:0] ivl, ivl_nxt;
    logic [K_W-1:0]   k, k_nxt;
    logic [2:0]       face_nxt;
    logic             rolling_nxt;
    logic             done_nxt;
    logic             step_due;

    assign step_due = (tmr == ivl - TMR_ONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            tmr     <= '0;
            ivl     <= IVL_INIT;
            k       <= '0;
            face    <= '0;
            rolling <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_nxt;
            tmr     <= tmr_nxt;
            ivl     <= ivl_nxt;
            k       <= k_nxt;
            face    <= face_nxt;
            rolling <= rolling_nxt;
            done    <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, SETTLED: if (roll) state_nxt = SPIN;
            SPIN:          if (!roll) state_nxt = SLOW;
            SLOW:          if (step_due && k == K_LAST) state_nxt = SETTLED;
            default:       state_nxt = IDLE;
        endcase
    end

    always_comb begin
        tmr_nxt  = tmr;
        ivl_nxt  = ivl;
        k_nxt    = k;
        face_nxt = face;
        done_nxt = 1'b0;
        case (state)
            IDLE, SETTLED: begin
                if (roll) begin
                    tmr_nxt = '0;
                    ivl_nxt = IVL_INIT;
                    k_nxt   = '0;
                end
            end
            SPIN: begin
                // Leaving SPIN wins over a step due on the same edge.
                if (!roll) begin
                    tmr_nxt = '0;
                end else if (step_due) begin
                    face_nxt = face + 3'd1;
                    tmr_nxt  = '0;
                end else begin
                    tmr_nxt = tmr + TMR_ONE;
                end
            end
            SLOW: begin
                if (step_due) begin
                    face_nxt = face + 3'd1;
                    tmr_nxt  = '0;
                    ivl_nxt  = ivl << 1;
                    k_nxt    = k + K_ONE;
                    done_nxt = (k == K_LAST);
                end else begin
                    tmr_nxt = tmr + TMR_ONE;
                end
            end
            default: ;
        endcase
        rolling_nxt = (state_nxt == SPIN) || (state_nxt == SLOW);
    end

`ifdef DICE_BLINK_EN
    localparam int BC_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BC_W-1:0] BLINK_LAST = BC_W'(BLINK_DIV - 1);
    localparam logic [BC_W-1:0] BC_ONE     = BC_W'(1);

    logic [BC_W-1:0] blink_cnt;
    logic [2:0]      blink_tog;
    logic            blink_on;

    // Counter is loaded with 0 on the settle edge so the first toggle
    // (blank 0->1) lands on the very next edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blank     <= 1'b0;
            blink_on  <= 1'b0;
            blink_cnt <= '0;
            blink_tog <= '0;
        end else if (done_nxt) begin
            blank     <= 1'b0;
            blink_on  <= 1'b1;
            blink_cnt <= '0;
            blink_tog <= '0;
        end else if (state == SETTLED && blink_on) begin
            if (roll) begin
                blank    <= 1'b0;
                blink_on <= 1'b0;
            end else if (blink_cnt == '0) begin
                blank     <= ~blank;
                blink_cnt <= BLINK_LAST;
                blink_tog <= blink_tog + 3'd1;
                if (blink_tog == 3'd5) blink_on <= 1'b0;
            end else begin
                blink_cnt <= blink_cnt - BC_ONE;
            end
        end
    end
`else
    assign blank = 1'b0;
`endif

endmodule

// File: tb/tb_dice_roll_sequencer.sv
module tb_dice_roll_sequencer;

    localparam int SPIN_DIV   = 2;
    localparam int SLOW_STEPS = 3;
    localparam int TMR_W      = 16;
    localparam int BLINK_DIV  = 8;
    localparam int NO_LIMIT   = 32'h3fff_ffff;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       roll = 1'b0;
    logic [2:0] face;
    logic       rolling;
    logic       done;
    logic       blank;

    dice_roll_sequencer #(
        .SPIN_DIV  (SPIN_DIV),
        .SLOW_STEPS(SLOW_STEPS),
        .TMR_W     (TMR_W),
        .BLINK_DIV (BLINK_DIV)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .roll   (roll),
        .face   (face),
        .rolling(rolling),
        .done   (done),
        .blank  (blank)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [2:0] face;
        logic       rolling;
        logic       done;
        logic       blank;
    } ev_t;

    ev_t exp_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;
    bit  mon_en = 1'b0;

    // Reference model: the output tuple after each edge on which it changes.
    logic [2:0] m_face;
    logic       m_rolling, m_done, m_blank;
    int         next_e;
    int         emit_lim = NO_LIMIT;
    int         prev_gap = 0;

    function automatic void emit(int c);
        ev_t e;
        if (c > emit_lim) return;
        e.cyc = c; e.face = m_face; e.rolling = m_rolling;
        e.done = m_done; e.blank = m_blank;
        if (exp_q.size() > 0 && exp_q[exp_q.size()-1].cyc == c)
            exp_q[exp_q.size()-1] = e;
        else
            exp_q.push_back(e);
    endfunction

    // One roll pressed at edge e0, held h further edges, next press at D+gap.
    // Returns the settle edge D.
    function automatic int gen_roll(int e0, int h, int gap);
        int t, iv;
        m_rolling = 1'b1; m_blank = 1'b0; m_done = 1'b0;
        emit(e0);
        for (int j = 1; j * SPIN_DIV <= h; j++) begin
            m_face = m_face + 3'd1;
            emit(e0 + j * SPIN_DIV);
        end
        t  = e0 + h + 1;
        iv = SPIN_DIV;
        for (int i = 0; i < SLOW_STEPS; i++) begin
            t  = t + iv;
            iv = iv * 2;
            m_face = m_face + 3'd1;
            if (i == SLOW_STEPS - 1) begin
                m_rolling = 1'b0;
                m_done    = 1'b1;
            end
            emit(t);
        end
        m_done = 1'b0;
`ifdef DICE_BLINK_EN
        if (gap > 1) m_blank = 1'b1;
        emit(t + 1);
        for (int b = 1; b < 6; b++) begin
            if (1 + b * BLINK_DIV < gap) begin
                m_blank = ~m_blank;
                emit(t + 1 + b * BLINK_DIV);
            end
        end
`else
        emit(t + 1);
`endif
        return t;
    endfunction

    function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    // Monitor: every change of the DUT output tuple is matched against the queue.
    logic [5:0] prev_t = 6'b0;
    always @(negedge clk) begin
        logic [5:0] cur;
        ev_t        e;
        cur = {face, rolling, done, blank};
        if (rst || !mon_en) begin
            prev_t = 6'b0;
        end else if (cur !== prev_t) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_change: cycle %0d got face=%0d rolling=%0b done=%0b blank=%0b, required no change",
                         cyc, face, rolling, done, blank);
            end else begin
                e = exp_q.pop_front();
                if (e.cyc != cyc || cur !== {e.face, e.rolling, e.done, e.blank}) begin
                    n_bad++;
                    $display("FAIL output_event: got cycle %0d face=%0d rolling=%0b done=%0b blank=%0b, required cycle %0d face=%0d rolling=%0b done=%0b blank=%0b",
                             cyc, face, rolling, done, blank, e.cyc, e.face, e.rolling, e.done, e.blank);
                end
            end
            prev_t = cur;
        end
    end

    task automatic sync_to(int tgt);
        do @(negedge clk); while (cyc < tgt);
    endtask

    task automatic run_roll(int h, bit pulse, int gap, bit early);
        int e0, d, c0, len;
        sync_to(next_e - 1 - int'(early));
        e0 = cyc + 1 + int'(early);
        d  = gen_roll(e0, h, gap);
        roll = 1'b1;
        if (early) @(negedge clk);
        repeat (h + 1) @(negedge clk);
        roll = 1'b0;
        if (pulse) begin
            c0  = $urandom_range(e0 + h + 1, d - 3);
            len = $urandom_range(1, d - 2 - c0);
            sync_to(c0);
            roll = 1'b1;
            repeat (len) @(negedge clk);
            roll = 1'b0;
        end
        next_e   = d + gap;
        prev_gap = gap;
    endtask

    task automatic reset_model();
        exp_q.delete();
        m_face = 3'd0; m_rolling = 1'b0; m_done = 1'b0; m_blank = 1'b0;
    endtask

    task automatic check_zero(string name);
        chk({name, "_face"}, 32'(face), 32'd0);
        chk({name, "_rolling"}, 32'(rolling), 32'd0);
        chk({name, "_done"}, 32'(done), 32'd0);
        chk({name, "_blank"}, 32'(blank), 32'd0);
    endtask

    // Reset lands one edge before the settle edge: no done may follow.
    task automatic run_abort(int h);
        int e0, d;
        sync_to(next_e - 1);
        e0 = cyc + 1;
        d  = e0 + h + 1 + SPIN_DIV * ((1 << SLOW_STEPS) - 1);
        emit_lim = d - 1;
        void'(gen_roll(e0, h, 50));
        emit_lim = NO_LIMIT;
        roll = 1'b1;
        repeat (h + 1) @(negedge clk);
        roll = 1'b0;
        sync_to(d - 1);
        #2 rst = 1'b1;
        #1 check_zero("abort_rst");
        chk("abort_queue_drained", 32'(exp_q.size()), 32'd0);
        reset_model();
        repeat (3) begin
            @(negedge clk);
            check_zero("abort_hold");
        end
        #2 rst = 1'b0;
        next_e = cyc + 3;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached at cycle %0d, required end of stimulus", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int h, gap;
        bit pulse, early;
        #3 rst = 1'b1;
        #1 check_zero("reset_async");
        repeat (3) begin
            @(negedge clk);
            check_zero("reset_hold");
        end
        #2 rst = 1'b0;
        reset_model();
        mon_en = 1'b1;
        next_e = cyc + 3;

        run_roll(10, 1'b0, 20, 1'b0);
        run_roll(10, 1'b1, 20, 1'b0);
        run_roll(1, 1'b0, 20, 1'b0);
        run_roll(1, 1'b0, 45, 1'b0);
        run_roll(3, 1'b1, 1, 1'b0);
        run_roll(2, 1'b0, 30, 1'b1);
        run_abort(4);

        for (int n = 0; n < 18; n++) begin
            h     = $urandom_range(0, 12);
            pulse = 1'($urandom_range(0, 1));
            gap   = ($urandom_range(0, 3) == 0) ? 1 : $urandom_range(2, 60);
            early = (prev_gap == 1) && ($urandom_range(0, 1) == 1);
            run_roll(h, pulse, gap, early);
        end

        sync_to(next_e + 50);
        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
